// File: rtl/mem_pkg.sv
// Shared encodings for the data memory unit: access sizes, error bits, FSM states
// and the byte-enable helper used by the lane steering logic.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_RANGE = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_lsu_align.sv
// Combinational lane logic: replicates store data across the word with byte enables,
// and extracts/extends the addressed byte or halfword of a loaded word.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign st_be = byte_enable(st_size, st_off);

  always_comb begin
    case (st_size)
      SZ_BYTE: st_lanes = {4{st_wdata[7:0]}};
      SZ_HALF: st_lanes = {2{st_wdata[15:0]}};
      default: st_lanes = st_wdata;
    endcase
  end

  assign ld_byte = 8'(ld_word >> {ld_off, 3'b000});
  assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Word-organised data memory with a request/response handshake and fixed access latency.
// The array access (store commit and load sample) happens on the edge that enters RESP.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_rd_q;

  logic             accept, in_idle, acc_fire, acc_we, acc_wr;
  logic [1:0]       acc_size, acc_err;
  logic [31:0]      acc_addr, acc_wdata, acc_off;
  logic [IDX_W-1:0] acc_idx;
  logic [3:0]       st_be;
  logic [31:0]      st_lanes, ld_data;

  assign in_idle = (state_q == IDLE);
  assign accept  = ready_q && req_valid;

  // In IDLE the access is described by the live inputs (needed when LATENCY is 1),
  // afterwards by the captured request.
  assign acc_wr    = in_idle ? req_wr    : wr_q;
  assign acc_size  = in_idle ? req_size  : size_q;
  assign acc_addr  = in_idle ? req_addr  : addr_q;
  assign acc_wdata = in_idle ? req_wdata : wdata_q;
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_idx   = acc_off[IDX_W+1:2];

  assign acc_err[ERR_ALIGN] = (acc_size == 2'b11)
                           || (acc_size == SZ_HALF && acc_addr[0])
                           || (acc_size == SZ_WORD && acc_addr[1:0] != 2'b00);
  assign acc_err[ERR_RANGE] = ({1'b0, acc_off} >= SPAN);

  assign acc_fire = (in_idle && accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 3'd1);
  assign acc_we   = acc_fire && acc_wr && (acc_err == 2'b00);

  lsu_align u_lsu_align (
    .st_size   (acc_size),
    .st_off    (acc_addr[1:0]),
    .st_wdata  (acc_wdata),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_size   (size_q),
    .ld_off    (addr_q[1:0]),
    .ld_signed (signed_q),
    .ld_word   (ram_rd_q),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    wr_d     = wr_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          wr_d     = req_wr;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = acc_err;
          ready_d  = 1'b0;
          if (LATENCY == 1) begin
            state_d = RESP;
            valid_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          valid_d = 1'b1;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain; the read is read-first.
  always_ff @(posedge clk) begin
    if (acc_fire) ram_rd_q <= mem[acc_idx];
    if (acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[acc_idx][i*8 +: 8] <= st_lanes[i*8 +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_err   = valid_q ? err_q : 2'b00;
  assign rsp_rdata = (valid_q && !wr_q && err_q == 2'b00) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: three instances (LATENCY 1 / 4 / 2 with BASE_ADDR 0x100)
// exercising word/half/byte accesses, errors, latency, backpressure and mid-access reset.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_wr     [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic [1:0]  rsp_err    [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_mem_unit #(
      .DEPTH_WORDS (256),
      .BASE_ADDR   (gi == 2 ? 32'h0000_0100 : 32'h0000_0000),
      .LATENCY     (gi == 1 ? 4 : (gi == 2 ? 2 : 1)),
      .INIT_FILE   ("")
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_wr     (req_wr[gi]),
      .req_size   (req_size[gi]),
      .req_signed (req_signed[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_err    (rsp_err[gi])
    );
  end

  // Drives one request, returns data/error and the cycle count from accept to rsp_valid
  // (lat = 99 if a bound expired).
  task automatic access(input int d, input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] err, output int lat);
    int guard = 0;
    rdata = 32'h0;
    err   = 2'b00;
    lat   = 99;
    @(negedge clk);
    while (!req_ready[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) return;
    req_valid[d]  = 1'b1;
    req_wr[d]     = wr;
    req_size[d]   = size;
    req_signed[d] = sgn;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid[d]) begin
      lat = 99;
      return;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    $display("txn dut%0d wr=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
             d, wr, size, sgn, addr, wdata, rdata, err, lat);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_size[d] = 2'b00; req_signed[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]} !== 35'h0)
      $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b want all zero",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (req_ready[1] !== 1'b0) $display("FAIL ready_before_edge got %b want 0", req_ready[1]);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (req_ready[1] !== 1'b1) $display("FAIL ready_after_release got %b want 1", req_ready[1]);
    else n_pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic [1:0] er; int lat;
    access(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, rd, er, lat);
    n_total++;
    if ({rd, er} !== 34'h0 || lat !== 1) $display("FAIL sw_40 got rdata=%h err=%b lat=%0d want 0 00 1", rd, er, lat);
    else n_pass++;
    access(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'hDEADBEEF || er !== 2'b00 || lat !== 1)
      $display("FAIL lw_40 got rdata=%h err=%b lat=%0d want deadbeef 00 1", rd, er, lat);
    else n_pass++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic [1:0] er; int lat;
    logic [31:0] exp_rd [4] = '{32'h0000007F, 32'hDEAD7FEF, 32'h000000DE, 32'hFFFFFFDE};
    logic [31:0] addrs  [4] = '{32'h41, 32'h40, 32'h43, 32'h43};
    logic [1:0]  sizes  [4] = '{2'b00, 2'b10, 2'b00, 2'b00};
    logic        sgns   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    access(0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0000007F, rd, er, lat);
    n_total++;
    if (er !== 2'b00 || lat !== 1) $display("FAIL sb_41 got err=%b lat=%0d want 00 1", er, lat);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      access(0, 1'b0, sizes[i], sgns[i], addrs[i], 32'h0, rd, er, lat);
      n_total++;
      if (rd !== exp_rd[i] || er !== 2'b00 || lat !== 1)
        $display("FAIL byte_load_%0d got rdata=%h err=%b lat=%0d want %h 00 1", i, rd, er, lat, exp_rd[i]);
      else n_pass++;
    end
  endtask

  task automatic test_half_align();
    logic [31:0] rd; logic [1:0] er; int lat;
    access(0, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'hFFFFDEAD || er !== 2'b00) $display("FAIL lh_42 got rdata=%h err=%b want ffffdead 00", rd, er);
    else n_pass++;
    access(0, 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'h00007FEF || er !== 2'b00) $display("FAIL lhu_40 got rdata=%h err=%b want 00007fef 00", rd, er);
    else n_pass++;
    access(0, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'h0 || er !== 2'b01 || lat !== 1) $display("FAIL lw_42 got rdata=%h err=%b lat=%0d want 0 01 1", rd, er, lat);
    else n_pass++;
    access(0, 1'b1, 2'b01, 1'b0, 32'h41, 32'h00001234, rd, er, lat);
    n_total++;
    if (er !== 2'b01) $display("FAIL sh_41 got err=%b want 01", er);
    else n_pass++;
    access(0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, rd, er, lat);
    n_total++;
    if (er !== 2'b01) $display("FAIL size11 got err=%b want 01", er);
    else n_pass++;
    access(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'hDEAD7FEF || er !== 2'b00) $display("FAIL lw_40_unchanged got rdata=%h err=%b want dead7fef 00", rd, er);
    else n_pass++;
  endtask

  task automatic test_range();
    logic [31:0] rd; logic [1:0] er; int lat;
    access(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, rd, er, lat);
    access(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h00000055, rd, er, lat);
    n_total++;
    if (er !== 2'b10 || lat !== 1) $display("FAIL sw_400 got err=%b lat=%0d want 10 1", er, lat);
    else n_pass++;
    access(0, 1'b1, 2'b01, 1'b0, 32'h401, 32'h00000066, rd, er, lat);
    n_total++;
    if (er !== 2'b11) $display("FAIL sh_401 got err=%b want 11", er);
    else n_pass++;
    access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'hA5A5A5A5 || er !== 2'b00) $display("FAIL lw_0_nowrite got rdata=%h err=%b want a5a5a5a5 00", rd, er);
    else n_pass++;
    access(0, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
    n_total++;
    if (er !== 2'b00) $display("FAIL lw_3fc got err=%b want 00", er);
    else n_pass++;
    access(2, 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'h0 || er !== 2'b10 || lat !== 2) $display("FAIL base_lw_fc got rdata=%h err=%b lat=%0d want 0 10 2", rd, er, lat);
    else n_pass++;
    access(2, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0BADF00D, rd, er, lat);
    access(2, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'h0BADF00D || er !== 2'b00 || lat !== 2)
      $display("FAIL base_lw_100 got rdata=%h err=%b lat=%0d want 0badf00d 00 2", rd, er, lat);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [31:0] rd, held; logic [1:0] er; int lat;
    access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, rd, er, lat);
    n_total++;
    if (lat !== 4 || er !== 2'b00) $display("FAIL lat4_sw got lat=%0d err=%b want 4 00", lat, er);
    else n_pass++;
    @(negedge clk);
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 32'h10;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      n_total++;
      if (rsp_valid[1] !== (i == 4) || req_ready[1] !== 1'b0)
        $display("FAIL lat4_cycle%0d got valid=%b ready=%b want %b 0", i, rsp_valid[1], req_ready[1], (i == 4));
      else n_pass++;
    end
    held = rsp_rdata[1];
    n_total++;
    if (held !== 32'hCAFEF00D) $display("FAIL lat4_lw got rdata=%h want cafef00d", held);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hCAFEF00D || req_ready[1] !== 1'b0)
        $display("FAIL stall_%0d got valid=%b rdata=%h ready=%b want 1 cafef00d 0", i, rsp_valid[1], rsp_rdata[1], req_ready[1]);
      else n_pass++;
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;
    n_total++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1)
      $display("FAIL after_handshake got valid=%b ready=%b want 0 1", rsp_valid[1], req_ready[1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_size[0] = 2'b10; req_signed[0] = 1'b0; req_addr[0] = 32'h40;
    @(posedge clk);
    #1 req_addr[0] = 32'h0;
    n_total++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEAD7FEF || req_ready[0] !== 1'b0)
      $display("FAIL b2b_first got valid=%b rdata=%h ready=%b want 1 dead7fef 0", rsp_valid[0], rsp_rdata[0], req_ready[0]);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
      $display("FAIL b2b_gap got valid=%b ready=%b want 0 1", rsp_valid[0], req_ready[0]);
    else n_pass++;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    n_total++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hA5A5A5A5)
      $display("FAIL b2b_second got valid=%b rdata=%h want 1 a5a5a5a5", rsp_valid[0], rsp_rdata[0]);
    else n_pass++;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] er; int lat;
    access(1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h11111111, rd, er, lat);
    @(negedge clk);
    req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_size[1] = 2'b10; req_addr[1] = 32'h80; req_wdata[1] = 32'h22222222;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]} !== 35'h0)
      $display("FAIL midreset_outputs got ready=%b valid=%b rdata=%h err=%b want all zero",
               req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    access(1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'h11111111 || er !== 2'b00 || lat !== 4)
      $display("FAIL midreset_lw_80 got rdata=%h err=%b lat=%0d want 11111111 00 4", rd, er, lat);
    else n_pass++;
    access(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_total++;
    if (rd !== 32'hDEAD7FEF) $display("FAIL midreset_mem_kept got rdata=%h want dead7fef", rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half_align();
    test_range();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
